// File: rtl/ov5640_sccb_cfg.sv
// OV5640 power-up sequencer and SCCB register-table loader.
// Lives in the CMOS_XCLK domain; cfg_done qualifies the capture path.
module ov5640_sccb_cfg #(
  parameter int unsigned CLK_DIV    = 60,
  parameter int unsigned PWR_DELAY  = 24000,
  parameter int unsigned RST_DELAY  = 24000,
  parameter int unsigned INIT_DELAY = 480000,
  parameter logic [7:0]  N_REGS     = 8'd200,
  parameter logic [7:0]  DEV_ADDR   = 8'h78,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        CMOS_XCLK,
  input  logic        cmos_rst_n,
  input  logic        start,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  output logic        cam_pwdn,
  output logic        cam_rst_n,
  output logic        sccb_scl,
  output logic        sccb_sda_o,
  output logic        sccb_sda_oe,
  input  logic        sccb_sda_i,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        ack_err
);

  localparam logic [19:0] T_PWR  = 20'(PWR_DELAY - 1);
  localparam logic [19:0] T_RST  = 20'(RST_DELAY - 1);
  localparam logic [19:0] T_INIT = 20'(INIT_DELAY - 1);
  localparam logic [19:0] T_Q    = 20'(CLK_DIV - 1);
  localparam logic [19:0] T_H    = 20'(2 * CLK_DIV - 1);
  localparam logic [19:0] T_GAP  = 20'(4 * CLK_DIV - 1);
  localparam logic [7:0]  RMAX   = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_PWR,
    S_RST,
    S_WAIT,
    S_START,
    S_BYTE,
    S_ACK,
    S_STOP,
    S_GAP,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [19:0] timer_q;
  logic [19:0] timer_d;
  logic [1:0]  ph_q;
  logic [2:0]  bit_q;
  logic [1:0]  byte_q;
  logic [23:0] data_q;
  logic [7:0]  retry_q;
  logic        nack_q;
  logic [7:0]  idx_q;
  logic        pwdn_q;
  logic        crst_q;
  logic        scl_q;
  logic        sda_q;
  logic        oe_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic        tmr_zero;
  logic        last_idx;
  logic [7:0]  cur_byte;
  logic        bit_nxt;
  logic        nxt_msb;

  assign tmr_zero = (timer_q == 20'd0);
  assign timer_d  = tmr_zero ? 20'd0 : timer_q - 20'd1;
  assign last_idx = (idx_q == N_REGS - 8'd1);
  assign bit_nxt  = cur_byte[3'd6 - bit_q];

  always_comb begin
    unique case (byte_q)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = data_q[23:16];
      2'd2:    cur_byte = data_q[15:8];
      default: cur_byte = data_q[7:0];
    endcase
    unique case (byte_q)
      2'd0:    nxt_msb = data_q[23];
      2'd1:    nxt_msb = data_q[15];
      default: nxt_msb = data_q[7];
    endcase
  end

  always_ff @(posedge CMOS_XCLK or negedge cmos_rst_n) begin
    if (!cmos_rst_n) begin
      state_q <= S_PWR;
      timer_q <= T_PWR;
      ph_q    <= 2'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      data_q  <= 24'd0;
      retry_q <= 8'd0;
      nack_q  <= 1'b0;
      idx_q   <= 8'd0;
      pwdn_q  <= 1'b1;
      crst_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      unique case (state_q)
        S_PWR: begin
          if (tmr_zero) begin
            state_q <= S_RST;
            timer_q <= T_RST;
            pwdn_q  <= 1'b0;
          end
        end
        S_RST: begin
          if (tmr_zero) begin
            state_q <= S_WAIT;
            timer_q <= T_INIT;
            crst_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (tmr_zero) begin
            state_q <= S_START;
            timer_q <= T_H;
            byte_q  <= 2'd0;
            bit_q   <= 3'd0;
            nack_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b0;
            oe_q    <= 1'b1;
          end
        end
        S_START: begin
          // index settles one cycle before the latch
          if (timer_q == T_H) data_q <= lut_data;
          if (tmr_zero) begin
            state_q <= S_BYTE;
            timer_q <= T_Q;
            ph_q    <= 2'd0;
            scl_q   <= 1'b0;
            sda_q   <= DEV_ADDR[7];
          end
        end
        S_BYTE: begin
          if (tmr_zero) begin
            timer_q <= T_Q;
            ph_q    <= ph_q + 2'd1;
            unique case (ph_q)
              2'd0:    scl_q <= 1'b1;
              2'd1:    scl_q <= 1'b1;
              2'd2:    scl_q <= 1'b0;
              default: begin
                if (bit_q == 3'd7) begin
                  state_q <= S_ACK;
                  bit_q   <= 3'd0;
                  oe_q    <= 1'b0;
                  sda_q   <= 1'b1;
                end else begin
                  bit_q <= bit_q + 3'd1;
                  sda_q <= bit_nxt;
                end
              end
            endcase
          end
        end
        S_ACK: begin
          if (ph_q == 2'd2 && timer_q == T_Q) nack_q <= sccb_sda_i;
          if (tmr_zero) begin
            timer_q <= T_Q;
            ph_q    <= ph_q + 2'd1;
            unique case (ph_q)
              2'd0:    scl_q <= 1'b1;
              2'd1:    scl_q <= 1'b1;
              2'd2:    scl_q <= 1'b0;
              default: begin
                oe_q <= 1'b1;
                if (nack_q || byte_q == 2'd3) begin
                  state_q <= S_STOP;
                  sda_q   <= 1'b0;
                end else begin
                  state_q <= S_BYTE;
                  byte_q  <= byte_q + 2'd1;
                  sda_q   <= nxt_msb;
                end
              end
            endcase
          end
        end
        S_STOP: begin
          if (tmr_zero) begin
            if (ph_q == 2'd0) begin
              ph_q    <= 2'd1;
              timer_q <= T_Q;
              scl_q   <= 1'b1;
            end else begin
              state_q <= S_GAP;
              timer_q <= T_GAP;
              ph_q    <= 2'd0;
              oe_q    <= 1'b0;
              sda_q   <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (tmr_zero) begin
            if (nack_q && retry_q < RMAX) begin
              retry_q <= retry_q + 8'd1;
              state_q <= S_START;
            end else begin
              retry_q <= 8'd0;
              if (nack_q) err_q <= 1'b1;
              if (last_idx) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_q + 8'd1;
                state_q <= S_START;
              end
            end
            if (!(last_idx && !(nack_q && retry_q < RMAX))) begin
              timer_q <= T_H;
              byte_q  <= 2'd0;
              bit_q   <= 3'd0;
              nack_q  <= 1'b0;
              scl_q   <= 1'b1;
              sda_q   <= 1'b0;
              oe_q    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state_q <= S_RST;
            timer_q <= T_RST;
            crst_q  <= 1'b0;
            idx_q   <= 8'd0;
            err_q   <= 1'b0;
            retry_q <= 8'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_PWR;
          timer_q <= T_PWR;
        end
      endcase
    end
  end

  assign lut_index   = idx_q;
  assign cam_pwdn    = pwdn_q;
  assign cam_rst_n   = crst_q;
  assign sccb_scl    = scl_q;
  assign sccb_sda_o  = sda_q;
  assign sccb_sda_oe = oe_q;
  assign cfg_busy    = busy_q;
  assign cfg_done    = done_q;
  assign ack_err     = err_q;

endmodule

// File: tb/tb_ov5640_sccb_cfg.sv
// Bench for ov5640_sccb_cfg: timeline model, SCCB slave, byte scoreboard.
// Small delays and a 2-entry table keep every scenario short.
module tb_ov5640_sccb_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  lut_index;
  logic [23:0] lut_data;
  logic        cam_pwdn, cam_rst_n, scl, sda_o, sda_oe, sda_i;
  logic        busy, done, err;
  logic        slave_low = 1'b0;

  always #5 clk = ~clk;

  assign lut_data = (lut_index == 8'd0) ? 24'h300812 : 24'h310303;
  assign sda_i    = sda_oe ? sda_o : ~slave_low;

  ov5640_sccb_cfg #(
    .CLK_DIV(2), .PWR_DELAY(10), .RST_DELAY(10), .INIT_DELAY(10),
    .N_REGS(8'd2), .DEV_ADDR(8'h78), .MAX_RETRY(3)
  ) dut (
    .CMOS_XCLK(clk), .cmos_rst_n(rst_n), .start(start),
    .lut_index(lut_index), .lut_data(lut_data),
    .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .sccb_scl(scl), .sccb_sda_o(sda_o), .sccb_sda_oe(sda_oe),
    .sccb_sda_i(sda_i), .cfg_busy(busy), .cfg_done(done),
    .ack_err(err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  // model: expected event times derived from bit/phase durations
  int att_e[$];
  int att_nb[$];
  int exp_st[$];
  logic [7:0] exp_rx[$];
  int got_st[$];
  logic [7:0] got_rx[$];
  bit m_pwr;
  int m_rlo, m_rhi, m_tfirst, m_tlut1, m_terr, m_tdone;

  task automatic att(input int e, input int nb);
    att_e.push_back(e);
    att_nb.push_back(nb);
  endtask

  task automatic plan(input int s, input bit pwr, input bit abandon);
    int t;
    logic [7:0] b[4];
    logic [23:0] w;
    m_pwr    = pwr;
    m_rlo    = pwr ? 0 : s;
    m_rhi    = pwr ? 20 : s + 10;
    m_tfirst = pwr ? 30 : s + 20;
    m_tlut1  = 1 << 30;
    exp_st.delete();
    exp_rx.delete();
    t = m_tfirst;
    foreach (att_e[k]) begin
      exp_st.push_back(t);
      if (att_e[k] == 1 && m_tlut1 > t) m_tlut1 = t;
      w = (att_e[k] == 0) ? 24'h300812 : 24'h310303;
      b[0] = 8'h78;
      b[1] = w[23:16];
      b[2] = w[15:8];
      b[3] = w[7:0];
      for (int j = 0; j < att_nb[k]; j++) exp_rx.push_back(b[j]);
      // START 4 + 72 per byte + STOP 4 + GAP 8
      t += 16 + 72 * att_nb[k];
    end
    m_tdone = t;
    m_terr  = abandon ? m_tlut1 : (1 << 30);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pwdn", cam_pwdn, m_pwr && cyc < 10);
      chk("cam_rst_n", cam_rst_n, !(cyc >= m_rlo && cyc < m_rhi));
      chk("cfg_done", done, cyc >= m_tdone);
      chk("cfg_busy", busy, cyc < m_tdone);
      chk("lut_index", lut_index, (cyc >= m_tlut1) ? 1 : 0);
      chk("ack_err", err, cyc >= m_terr);
      if (cyc < m_tfirst) begin
        chk("idle_scl", scl, 1);
        chk("idle_oe", sda_oe, 0);
      end
    end
  end

  // SCCB slave, sampled once per clock
  bit p_scl = 1'b1, p_sda = 1'b1, in_ack = 1'b0;
  int bitcnt = 0, bytecnt = 0, nacks = 0, nack_mode = 0;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    logic cs, cd;
    cs = scl;
    cd = sda_i;
    if (!rst_n) begin
      p_scl = 1'b1; p_sda = 1'b1; in_ack = 1'b0;
      bitcnt = 0; bytecnt = 0; slave_low = 1'b0;
    end else begin
      if (p_scl && cs && p_sda && !cd) begin
        got_st.push_back(cyc);
        bitcnt = 0; bytecnt = 0; in_ack = 1'b0; slave_low = 1'b0;
      end else if (p_scl && cs && !p_sda && cd) begin
        bitcnt = 0; in_ack = 1'b0;
      end else if (!p_scl && cs && !in_ack && bitcnt < 8) begin
        sh = {sh[6:0], cd};
        bitcnt++;
      end else if (p_scl && !cs) begin
        if (in_ack) begin
          slave_low = 1'b0; in_ack = 1'b0; bitcnt = 0; bytecnt++;
        end else if (bitcnt == 8) begin
          got_rx.push_back(sh);
          in_ack = 1'b1;
          if (bytecnt == 1 && sh == 8'h30 &&
              (nack_mode == 2 || (nack_mode == 1 && nacks == 0))) begin
            nacks++;
            slave_low = 1'b0;
          end else begin
            slave_low = 1'b1;
          end
        end
      end
      p_scl = cs;
      p_sda = cd;
    end
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, done, 1);
  endtask

  task automatic scn_check(input string nm);
    chk({nm, "_nstart"}, got_st.size(), exp_st.size());
    foreach (exp_st[i])
      if (i < got_st.size()) chk({nm, "_start_t"}, got_st[i], exp_st[i]);
    chk({nm, "_nrx"}, got_rx.size(), exp_rx.size());
    foreach (exp_rx[i])
      if (i < got_rx.size()) chk({nm, "_rx"}, got_rx[i], exp_rx[i]);
    got_st.delete();
    got_rx.delete();
    att_e.delete();
    att_nb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 chk_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got_st.delete();
    got_rx.delete();
    att_e.delete();
    att_nb.delete();
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  logic [7:0] lit1 [8] = '{8'h78, 8'h30, 8'h08, 8'h12,
                           8'h78, 8'h31, 8'h03, 8'h03};
  int s;

  initial begin
    // all ACK, plus an ignored start mid-transfer
    repeat (3) @(negedge clk);
    chk("rst_pwdn", cam_pwdn, 1);
    chk("rst_scl", scl, 1);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 1);
    att(0, 4); att(1, 4);
    plan(0, 1'b1, 1'b0);
    release_rst();
    while (cyc < 100) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    wait_done("s1");
    chk("s1_done_cyc", cyc, 638);
    repeat (3) @(negedge clk);
    chk("s1_err", err, 0);
    chk("s1_idx", lut_index, 1);
    if (got_st.size() > 0) chk("s1_first_start", got_st[0], 30);
    chk("s1_nrx_lit", got_rx.size(), 8);
    foreach (lit1[i])
      if (i < got_rx.size()) chk("s1_rx_lit", got_rx[i], lit1[i]);
    scn_check("s1");

    // entry 0 always NACKed: 4 attempts then abandoned
    do_reset();
    nack_mode = 2;
    nacks = 0;
    repeat (4) att(0, 2);
    att(1, 4);
    plan(0, 1'b1, 1'b1);
    release_rst();
    wait_done("s3");
    repeat (3) @(negedge clk);
    chk("s3_err", err, 1);
    chk("s3_nstart_lit", got_st.size(), 5);
    chk("s3_done_lit", m_tdone, 974);
    scn_check("s3");

    // start from DONE, entry 0 NACKed once
    @(negedge clk);
    #1 nack_mode = 1;
    nacks = 0;
    att(0, 2); att(0, 4); att(1, 4);
    s = cyc + 1;
    plan(s, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    wait_done("s2");
    chk("s2_done_cyc", cyc, s + 788);
    repeat (3) @(negedge clk);
    chk("s2_err", err, 0);
    chk("s2_nrx_lit", got_rx.size(), 10);
    scn_check("s2");

    // restart, then async reset in the middle of the address byte
    @(negedge clk);
    #1 nack_mode = 0;
    att(0, 4); att(1, 4);
    s = cyc + 1;
    plan(s, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    while (cyc < s + 48) @(negedge clk);
    chk("mid_scl_low", scl, 0);
    chk("mid_oe", sda_oe, 1);
    #1 chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_scl", scl, 1);
    chk("arst_oe", sda_oe, 0);
    chk("arst_pwdn", cam_pwdn, 1);
    chk("arst_crst", cam_rst_n, 0);
    repeat (3) @(negedge clk);
    got_st.delete();
    got_rx.delete();
    att_e.delete();
    att_nb.delete();
    att(0, 4); att(1, 4);
    plan(0, 1'b1, 1'b0);
    release_rst();
    wait_done("s5");
    chk("s5_done_cyc", cyc, 638);
    repeat (3) @(negedge clk);
    scn_check("s5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
